// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB bridge: one APB transfer per AHB transfer, one wait state minimum.
// Unmapped slave indices get a two-cycle AHB ERROR response without touching APB.
module ahb2apb_bridge #(
    parameter int unsigned NUM_PSLV = 4,
    parameter int unsigned SEL_LSB  = 12
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic [1:0]          HTRANS,
    input  logic [31:0]         HADDR,
    input  logic                HWRITE,
    input  logic [31:0]         HWDATA,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    output logic [1:0]          HRESP,
    output logic [31:0]         PADDR,
    output logic                PWRITE,
    output logic [31:0]         PWDATA,
    output logic [NUM_PSLV-1:0] PSEL,
    output logic                PENABLE,
    input  logic [31:0]         PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    state_e state_q, state_d;

    logic [31:0]         addr_q;
    logic                write_q;
    logic [3:0]          idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          new_idx;
    logic                sample;
    logic                mapped;
    logic                done_ok;
    logic                accept;
    logic [NUM_PSLV-1:0] sel_onehot;
    logic                unused_htrans;

    assign unused_htrans = HTRANS[0];
    assign new_idx       = HADDR[SEL_LSB+3:SEL_LSB];
    assign sample        = HSEL & HREADY & HTRANS[1];
    assign mapped        = 32'(new_idx) < NUM_PSLV;
    assign done_ok       = (state_q == StAccess) & PREADY & ~PSLVERR;
    // A new transfer can only be taken in cycles where the bridge itself reports ready.
    assign accept        = sample & ((state_q == StIdle) | (state_q == StErr2) | done_ok);

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_PSLV; i++) begin
            sel_onehot[i] = (idx_q == 4'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StSetup:  state_d = StAccess;
            StAccess: if (PREADY) state_d = PSLVERR ? StErr1 : StIdle;
            StErr1:   state_d = StErr2;
            default:  state_d = StIdle;
        endcase
        if (accept) begin
            state_d = mapped ? StSetup : StErr1;
        end
    end

    always_comb begin
        PSEL      = '0;
        PENABLE   = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = '0;
        PWDATA    = wdata_q;
        case (state_q)
            StSetup: begin
                PSEL      = sel_onehot;
                HREADYOUT = 1'b0;
                PWDATA    = HWDATA;
            end
            StAccess: begin
                PSEL      = sel_onehot;
                PENABLE   = 1'b1;
                HREADYOUT = PREADY & ~PSLVERR;
                HRDATA    = PRDATA;
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
            end
            StErr2: begin
                HRESP     = 2'b01;
            end
            default: ;
        endcase
    end

    assign PADDR  = addr_q;
    assign PWRITE = write_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                idx_q   <= new_idx;
            end
            // Data phase HWDATA is only guaranteed in SETUP; hold it for ACCESS.
            if (state_q == StSetup) begin
                wdata_q <= HWDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: directed scenarios with literal expectations, then a random
// transaction timeline whose per-cycle expected outputs are derived from transfer rules.
module tb_ahb2apb_bridge;

    localparam int NP = 4;
    localparam int NC = 1500;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          HSEL, HREADY, HWRITE, PREADY, PSLVERR;
    logic [1:0]    HTRANS;
    logic [31:0]   HADDR, HWDATA, PRDATA;
    logic [31:0]   HRDATA, PADDR, PWDATA;
    logic          HREADYOUT, PWRITE, PENABLE;
    logic [1:0]    HRESP;
    logic [NP-1:0] PSEL;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        hsel;
        logic        hready;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic        hwrite;
        logic [31:0] hwdata;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
    } stim_t;

    typedef struct {
        logic        apb;
        logic [3:0]  psel;
        logic        penable;
        logic        hreadyout;
        logic [1:0]  hresp;
        logic [31:0] hrdata;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
    } exp_t;

    stim_t stim[NC];
    exp_t  expv[NC];

    ahb2apb_bridge #(.NUM_PSLV(NP), .SEL_LSB(12)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
        .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        @(negedge HCLK);
    endtask

    task automatic idle_bus();
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HREADY = 1'b1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = a;
        HWRITE = w;
        HREADY = 1'b1;
    endtask

    // Random bus activity that never forms a transfer the bridge may take.
    task automatic set_bus(input int c, input logic rdy);
        stim[c].hready = rdy;
        stim[c].haddr = $urandom;
        stim[c].hwrite = 1'($urandom);
        if (!rdy) begin
            stim[c].hsel = 1'b1;
            stim[c].htrans = {1'b1, 1'($urandom)};
        end else if ($urandom_range(0, 1) == 0) begin
            stim[c].hsel = 1'b0;
            stim[c].htrans = 2'($urandom);
        end else begin
            stim[c].hsel = 1'b1;
            stim[c].htrans = {1'b0, 1'($urandom)};
        end
    endtask

    task automatic set_idle_exp(input int c);
        expv[c].apb = 1'b0;
        expv[c].psel = 4'b0000;
        expv[c].penable = 1'b0;
        expv[c].hreadyout = 1'b1;
        expv[c].hresp = 2'b00;
        expv[c].hrdata = 32'h0;
        expv[c].paddr = 32'h0;
        expv[c].pwrite = 1'b0;
        expv[c].pwdata = 32'h0;
    endtask

    task automatic err_cycles(input int c);
        set_bus(c, 1'b0);
        set_idle_exp(c);
        expv[c].hreadyout = 1'b0;
        expv[c].hresp = 2'b01;
        set_bus(c + 1, 1'b1);
        set_idle_exp(c + 1);
        expv[c + 1].hresp = 2'b01;
    endtask

    task automatic build_timeline();
        int a, nxt, w, c;
        logic [3:0] idx;
        logic [31:0] addr, wd;
        logic wr, err, rdy, last;
        logic [1:0] tr;
        for (int i = 0; i < NC; i++) begin
            set_bus(i, $urandom_range(0, 3) != 0);
            stim[i].hwdata = $urandom;
            stim[i].pready = 1'($urandom);
            stim[i].pslverr = 1'($urandom);
            stim[i].prdata = $urandom;
            set_idle_exp(i);
        end
        a = 2;
        while (a < NC - 20) begin
            idx = 4'($urandom_range(0, 7));
            addr = $urandom;
            addr[15:12] = idx;
            wr = 1'($urandom);
            tr = {1'b1, 1'($urandom)};
            if (32'(idx) < NP) begin
                wd = $urandom;
                w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                err = ($urandom_range(0, 5) == 0);
                for (int k = 1; k <= w + 2; k++) begin
                    c = a + k;
                    last = (k == w + 2);
                    rdy = last && !err;
                    set_bus(c, rdy);
                    expv[c].apb = 1'b1;
                    expv[c].psel = 4'b0001 << idx;
                    expv[c].penable = (k > 1);
                    expv[c].hreadyout = rdy;
                    expv[c].hresp = 2'b00;
                    expv[c].paddr = addr;
                    expv[c].pwrite = wr;
                    expv[c].pwdata = wd;
                    expv[c].hrdata = (k > 1) ? stim[c].prdata : 32'h0;
                    if (k == 1) begin
                        stim[c].hwdata = wd;
                    end else if (!last) begin
                        stim[c].pready = 1'b0;
                    end else begin
                        stim[c].pready = 1'b1;
                        stim[c].pslverr = err;
                    end
                end
                if (err) begin
                    err_cycles(a + w + 3);
                    nxt = a + w + 4;
                end else begin
                    nxt = a + w + 2;
                end
            end else begin
                err_cycles(a + 1);
                nxt = a + 2;
            end
            stim[a].hsel = 1'b1;
            stim[a].hready = 1'b1;
            stim[a].htrans = tr;
            stim[a].haddr = addr;
            stim[a].hwrite = wr;
            a = nxt + (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
        end
    endtask

    task automatic compare_cycle(input int c);
        chk($sformatf("psel@%0d", c), 32'(PSEL), 32'(expv[c].psel));
        chk($sformatf("penable@%0d", c), 32'(PENABLE), 32'(expv[c].penable));
        chk($sformatf("hreadyout@%0d", c), 32'(HREADYOUT), 32'(expv[c].hreadyout));
        chk($sformatf("hresp@%0d", c), 32'(HRESP), 32'(expv[c].hresp));
        chk($sformatf("hrdata@%0d", c), HRDATA, expv[c].hrdata);
        if (expv[c].apb) begin
            chk($sformatf("paddr@%0d", c), PADDR, expv[c].paddr);
            chk($sformatf("pwrite@%0d", c), 32'(PWRITE), 32'(expv[c].pwrite));
            chk($sformatf("pwdata@%0d", c), PWDATA, expv[c].pwdata);
        end
    endtask

    initial begin
        idle_bus();
        HADDR = 32'h0;
        HWRITE = 1'b0;
        HWDATA = 32'h1111_1111;
        PRDATA = 32'hA5A5_A5A5;
        PREADY = 1'b1;
        PSLVERR = 1'b0;
        settle();
        settle();
        chk("rst_psel", 32'(PSEL), 32'h0);
        chk("rst_penable", 32'(PENABLE), 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwrite", 32'(PWRITE), 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        next_cycle();
        HRESET = 1'b0;

        // Zero-wait write right after reset release.
        addr_phase(32'h0000_1004, 1'b1);
        next_cycle();
        idle_bus();
        HWDATA = 32'hDEAD_BEEF;
        settle();
        chk("wr_setup_psel", 32'(PSEL), 32'h2);
        chk("wr_setup_penable", 32'(PENABLE), 32'h0);
        chk("wr_setup_paddr", PADDR, 32'h0000_1004);
        chk("wr_setup_pwrite", 32'(PWRITE), 32'h1);
        chk("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        chk("wr_setup_hreadyout", 32'(HREADYOUT), 32'h0);
        next_cycle();
        settle();
        chk("wr_access_penable", 32'(PENABLE), 32'h1);
        chk("wr_access_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("wr_access_hresp", 32'(HRESP), 32'h0);
        next_cycle();
        settle();
        chk("wr_idle_psel", 32'(PSEL), 32'h0);

        // Read with three APB wait states; a decoy address phase is presented meanwhile.
        next_cycle();
        addr_phase(32'h0000_3000, 1'b0);
        next_cycle();
        addr_phase(32'h0000_1000, 1'b1);
        HREADY = 1'b0;
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            settle();
            chk("rd_wait_hreadyout", 32'(HREADYOUT), 32'h0);
            chk("rd_wait_paddr", PADDR, 32'h0000_3000);
        end
        next_cycle();
        idle_bus();
        PREADY = 1'b1;
        settle();
        chk("rd_done_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rd_done_hrdata", HRDATA, 32'h1234_5678);
        chk("rd_done_paddr", PADDR, 32'h0000_3000);
        chk("rd_done_psel", 32'(PSEL), 32'h8);

        // Slave error on index 2.
        next_cycle();
        addr_phase(32'h0000_2000, 1'b0);
        next_cycle();
        idle_bus();
        HREADY = 1'b0;
        PSLVERR = 1'b1;
        settle();
        chk("slverr_setup_psel", 32'(PSEL), 32'h4);
        next_cycle();
        settle();
        chk("slverr_access_hreadyout", 32'(HREADYOUT), 32'h0);
        chk("slverr_access_hresp", 32'(HRESP), 32'h0);
        next_cycle();
        PSLVERR = 1'b0;
        settle();
        chk("slverr_err1_hreadyout", 32'(HREADYOUT), 32'h0);
        chk("slverr_err1_hresp", 32'(HRESP), 32'h1);
        chk("slverr_err1_psel", 32'(PSEL), 32'h0);
        next_cycle();
        HREADY = 1'b1;
        settle();
        chk("slverr_err2_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("slverr_err2_hresp", 32'(HRESP), 32'h1);
        next_cycle();
        settle();
        chk("slverr_idle_hresp", 32'(HRESP), 32'h0);

        // Unmapped index 7.
        next_cycle();
        addr_phase(32'h0000_7000, 1'b1);
        next_cycle();
        idle_bus();
        HREADY = 1'b0;
        settle();
        chk("unmap_err1_psel", 32'(PSEL), 32'h0);
        chk("unmap_err1_penable", 32'(PENABLE), 32'h0);
        chk("unmap_err1_hreadyout", 32'(HREADYOUT), 32'h0);
        chk("unmap_err1_hresp", 32'(HRESP), 32'h1);
        next_cycle();
        HREADY = 1'b1;
        settle();
        chk("unmap_err2_psel", 32'(PSEL), 32'h0);
        chk("unmap_err2_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("unmap_err2_hresp", 32'(HRESP), 32'h1);
        next_cycle();
        settle();
        chk("unmap_idle_hresp", 32'(HRESP), 32'h0);

        // Back-to-back zero-wait writes.
        next_cycle();
        addr_phase(32'h0000_0000, 1'b1);
        next_cycle();
        idle_bus();
        HREADY = 1'b0;
        HWDATA = 32'hCAFE_0001;
        settle();
        chk("b2b_1_psel", 32'(PSEL), 32'h1);
        chk("b2b_1_pwdata", PWDATA, 32'hCAFE_0001);
        next_cycle();
        addr_phase(32'h0000_2000, 1'b1);
        settle();
        chk("b2b_2_psel", 32'(PSEL), 32'h1);
        chk("b2b_2_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("b2b_2_pwdata", PWDATA, 32'hCAFE_0001);
        next_cycle();
        idle_bus();
        HREADY = 1'b0;
        HWDATA = 32'hCAFE_0002;
        settle();
        chk("b2b_3_psel", 32'(PSEL), 32'h4);
        chk("b2b_3_paddr", PADDR, 32'h0000_2000);
        chk("b2b_3_pwdata", PWDATA, 32'hCAFE_0002);
        next_cycle();
        HREADY = 1'b1;
        settle();
        chk("b2b_4_psel", 32'(PSEL), 32'h4);
        chk("b2b_4_penable", 32'(PENABLE), 32'h1);
        chk("b2b_4_pwdata", PWDATA, 32'hCAFE_0002);
        next_cycle();
        settle();

        // Asynchronous reset in the middle of a stalled ACCESS.
        next_cycle();
        addr_phase(32'h0000_1000, 1'b0);
        next_cycle();
        idle_bus();
        HREADY = 1'b0;
        PREADY = 1'b0;
        settle();
        next_cycle();
        settle();
        chk("arst_pre_penable", 32'(PENABLE), 32'h1);
        #1 HRESET = 1'b1;
        #1;
        chk("arst_psel", 32'(PSEL), 32'h0);
        chk("arst_penable", 32'(PENABLE), 32'h0);
        chk("arst_hreadyout", 32'(HREADYOUT), 32'h1);
        next_cycle();
        HRESET = 1'b0;
        idle_bus();
        PREADY = 1'b1;
        settle();
        chk("arst_after_psel", 32'(PSEL), 32'h0);

        // Random transaction timeline.
        build_timeline();
        for (int c = 0; c < NC; c++) begin
            next_cycle();
            HSEL = stim[c].hsel;
            HREADY = stim[c].hready;
            HTRANS = stim[c].htrans;
            HADDR = stim[c].haddr;
            HWRITE = stim[c].hwrite;
            HWDATA = stim[c].hwdata;
            PREADY = stim[c].pready;
            PSLVERR = stim[c].pslverr;
            PRDATA = stim[c].prdata;
            settle();
            compare_cycle(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
